// File: rtl/snake_dir_queue.sv
// Snake direction controller: synchronised and debounced push-buttons feed a
// small circular queue of pending turns, which the game-step tick pops into move_state.
module snake_dir_queue #(
  parameter int         DEB_CYCLES = 16,
  parameter int         QDEPTH     = 2,
  parameter logic [1:0] INIT_DIR   = 2'd3,
  localparam int        CW         = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    btn,
  input  logic          tick,
  output logic [1:0]    move_state,
  output logic          dir_changed,
  output logic [CW-1:0] q_count,
  output logic          drop
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic [3:0]    sync1, sync2, deb, deb_d, press;
  logic [DW-1:0] cnt [4];
  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, last_ptr;
  logic [1:0]    cand, tail;
  logic          cand_valid, accept, pop, push, full;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      deb_d <= deb;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press = deb & ~deb_d;

  // Only the highest-priority press of a cycle is considered; the rest vanish.
  always_comb begin
    cand_valid = 1'b1;
    cand       = 2'd0;
    if (press[0])      cand = 2'd0;
    else if (press[1]) cand = 2'd1;
    else if (press[2]) cand = 2'd2;
    else if (press[3]) cand = 2'd3;
    else               cand_valid = 1'b0;
  end

  assign last_ptr = (wr_ptr == '0) ? PW'(QDEPTH - 1) : wr_ptr - 1'b1;
  assign tail     = (q_count != '0) ? mem[last_ptr] : move_state;
  // tail^1 is the opposite direction, so this rejects both repeats and reversals.
  assign accept   = cand_valid && (cand != tail) && (cand != (tail ^ 2'd1));
  assign full     = (q_count == CW'(QDEPTH));
  assign pop      = tick && (q_count != '0);
  assign push     = accept && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      move_state  <= INIT_DIR;
      dir_changed <= 1'b0;
      drop        <= 1'b0;
      q_count     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else begin
      dir_changed <= pop;
      drop        <= accept && full && !pop;
      if (pop) begin
        move_state <= mem[rd_ptr];
        rd_ptr     <= ptr_next(rd_ptr);
      end
      if (push) begin
        mem[wr_ptr] <= cand;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (push && !pop)      q_count <= q_count + 1'b1;
      else if (pop && !push) q_count <= q_count - 1'b1;
    end
  end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Directed bench for snake_dir_queue: a vector table of presses/ticks plus
// hand sequences for glitch rejection, push-during-pop and asynchronous reset.
module tb_snake_dir_queue;

  localparam int DEB = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'h0;
  logic       tick = 1'b0;
  logic [1:0] move_state;
  logic       dir_changed;
  logic [1:0] q_count;
  logic       drop;

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  int dc_cnt = 0;

  typedef struct {
    logic [3:0] btn;
    logic       do_tick;
    logic [1:0] ms;
    int         q;
    int         drops;
    int         dcs;
  } vec_t;

  vec_t vecs[21];

  snake_dir_queue #(.DEB_CYCLES(DEB), .QDEPTH(2), .INIT_DIR(2'd3)) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .tick(tick),
    .move_state(move_state), .dir_changed(dir_changed),
    .q_count(q_count), .drop(drop)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (drop) drop_cnt++;
    if (dir_changed) dc_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input logic [3:0] mask);
    @(negedge clk) btn = mask;
    repeat (40) @(negedge clk);
    btn = 4'h0;
    repeat (40) @(negedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clear_cnts();
    @(negedge clk);
    drop_cnt = 0;
    dc_cnt = 0;
  endtask

  task automatic check_state(input string tag, input int ms, input int q, input int drops, input int dcs);
    chk({tag, " move_state"}, int'(move_state), ms);
    chk({tag, " q_count"}, int'(q_count), q);
    chk({tag, " drop pulses"}, drop_cnt, drops);
    chk({tag, " dir_changed pulses"}, dc_cnt, dcs);
  endtask

  initial begin
    //           btn    tick  ms    q  drops dcs
    vecs[0]  = '{4'h1, 1'b0, 2'd3, 1, 0, 0};  // Up queued from RIGHT
    vecs[1]  = '{4'h0, 1'b1, 2'd0, 0, 0, 1};
    vecs[2]  = '{4'h0, 1'b1, 2'd0, 0, 0, 0};  // empty tick
    vecs[3]  = '{4'h4, 1'b0, 2'd0, 1, 0, 0};
    vecs[4]  = '{4'h1, 1'b0, 2'd0, 2, 0, 0};  // tail is LEFT, Up valid
    vecs[5]  = '{4'h2, 1'b0, 2'd0, 2, 0, 0};  // Down opposite of tail Up
    vecs[6]  = '{4'h8, 1'b0, 2'd0, 2, 1, 0};  // valid but full
    vecs[7]  = '{4'h0, 1'b1, 2'd2, 1, 0, 1};
    vecs[8]  = '{4'h0, 1'b1, 2'd0, 0, 0, 1};
    vecs[9]  = '{4'hA, 1'b0, 2'd0, 0, 0, 0};  // Down wins, rejected; Right dropped silently
    vecs[10] = '{4'h4, 1'b0, 2'd0, 1, 0, 0};
    vecs[11] = '{4'h0, 1'b1, 2'd2, 0, 0, 1};
    vecs[12] = '{4'h8, 1'b0, 2'd2, 0, 0, 0};  // reversal
    vecs[13] = '{4'h4, 1'b0, 2'd2, 0, 0, 0};  // duplicate
    vecs[14] = '{4'h9, 1'b0, 2'd2, 1, 0, 0};  // Up beats Right
    vecs[15] = '{4'h0, 1'b1, 2'd0, 0, 0, 1};
    vecs[16] = '{4'h8, 1'b0, 2'd0, 1, 0, 0};
    vecs[17] = '{4'h0, 1'b1, 2'd3, 0, 0, 1};
    vecs[18] = '{4'h1, 1'b0, 2'd3, 1, 0, 0};
    vecs[19] = '{4'h4, 1'b0, 2'd3, 2, 0, 0};
    vecs[20] = '{4'h2, 1'b0, 2'd3, 2, 1, 0};  // Down valid vs LEFT, queue full

    repeat (2) @(negedge clk);
    check_state("reset", 3, 0, 0, 0);
    chk("reset drop", int'(drop), 0);
    chk("reset dir_changed", int'(dir_changed), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Glitch on Left shorter than the debounce window: ignored.
    clear_cnts();
    btn = 4'h4;
    repeat (DEB - 2) @(negedge clk);
    btn = 4'h0;
    repeat (40) @(negedge clk);
    do_tick();
    do_tick();
    check_state("glitch", 3, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      clear_cnts();
      if (vecs[i].btn != 4'h0) press(vecs[i].btn);
      if (vecs[i].do_tick) do_tick();
      check_state($sformatf("vec%0d", i), vecs[i].ms, vecs[i].q, vecs[i].drops, vecs[i].dcs);
    end

    // Queue holds [Up, Left], move_state RIGHT. Down's press event is lined up
    // with a tick: pop and push share the edge, so no drop and q_count stays 2.
    clear_cnts();
    @(negedge clk) btn = 4'h2;
    repeat (DEB + 2) @(posedge clk);
    @(negedge clk) tick = 1'b1;
    @(negedge clk) tick = 1'b0;
    chk("pushpop q_count", int'(q_count), 2);
    chk("pushpop move_state", int'(move_state), 0);
    repeat (40) @(negedge clk);
    btn = 4'h0;
    repeat (40) @(negedge clk);
    check_state("pushpop", 0, 2, 0, 1);

    clear_cnts();
    do_tick();
    check_state("drain1", 2, 1, 0, 1);
    clear_cnts();
    do_tick();
    check_state("drain2", 1, 0, 0, 1);
    clear_cnts();
    do_tick();
    check_state("drain3", 1, 0, 0, 0);

    // Pulse just past the debounce window does register.
    clear_cnts();
    @(negedge clk) btn = 4'h4;
    repeat (DEB + 2) @(negedge clk);
    btn = 4'h0;
    repeat (40) @(negedge clk);
    check_state("longpulse", 1, 1, 0, 0);
    press(4'h1);
    chk("prereset q_count", int'(q_count), 2);

    // Asynchronous reset between clock edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst move_state", int'(move_state), 3);
    chk("async rst q_count", int'(q_count), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_cnts();
    do_tick();
    check_state("after reset", 3, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_dir_queue.md
Name: snake_dir_queue

Overview:
- Next-generation direction controller for the snake game.
- Turns four raw push-buttons into the snake's movement direction, sampled by the game-step tick.
- Adds input synchronisation, per-button debounce, rising-edge detection, and a parametrised FIFO of pending turns, so fast double-taps between two game steps (e.g. UP then LEFT) are both honoured in order.
- Sits between the board buttons and the snake movement/render logic; move_state drives the head-update logic directly.

Parameters:
- DEB_CYCLES, 16: consecutive stable cycles required before a debounced button level changes (must be >= 1).
- QDEPTH, 2: number of pending turns the queue holds (must be >= 1).
- INIT_DIR, 3: direction loaded into move_state at reset (0=UP, 1=DOWN, 2=LEFT, 3=RIGHT).
- CW, $clog2(QDEPTH+1): width of q_count; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- btn  in  4  raw buttons, asynchronous to clk: [0]=Up, [1]=Down, [2]=Left, [3]=Right; active high.
- tick  in  1  one-cycle game-step strobe from the snake timer.
- move_state  out  2  current direction; encoding UP=0, DOWN=1, LEFT=2, RIGHT=3.
- dir_changed  out  1  one-cycle pulse when move_state is updated from the queue.
- q_count  out  CW  number of pending turns, 0..QDEPTH.
- drop  out  1  one-cycle pulse when a valid turn is discarded because the queue is full.

Interface: one clock; reset is asynchronous and active-low.
- All state resets immediately on rst_n low and is held until rst_n goes high.

Behaviour:
- Reset values:
  - move_state = INIT_DIR; dir_changed = 0; q_count = 0; drop = 0.
  - Synchroniser flops, debounced levels and debounce counters all 0.
- Synchronisation: each btn bit passes through a 2-flop synchroniser.
- Debounce, per button:
  - The counter resets to 0 whenever the synchronised level equals the debounced level.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1 while the mismatch persists, the debounced level flips and the counter clears.
  - Glitches shorter than DEB_CYCLES cycles never change the debounced level.
- Press event: a rising edge of a debounced level, lasting one cycle.
  - Latency: btn held high from cycle 0 gives a press event in cycle DEB_CYCLES+2 (±1 for asynchronous sampling).
  - Release events are ignored.
- Simultaneous press events: priority Up > Down > Left > Right; the lower-priority events that cycle are discarded without asserting drop.
- Acceptance check:
  - tail = newest queue entry if q_count > 0, else move_state.
  - The candidate is rejected (silently) if it equals tail or equals tail^1. Opposite pairs are 0/1 and 2/3, so no reversal into the body and no duplicate entries.
  - Accepted candidate with q_count < QDEPTH: pushed.
  - Accepted candidate with q_count == QDEPTH and no pop this cycle: discarded, drop=1 for one cycle.
- Tick with q_count > 0:
  - Head entry is popped into move_state at the same clock edge; dir_changed=1 for one cycle.
  - Only one entry is consumed per tick.
- Tick with q_count = 0: move_state holds; dir_changed stays 0.
- Simultaneous push and pop in the same cycle:
  - Both occur; q_count is unchanged.
  - Tail is evaluated on pre-edge contents.
  - A push into a full queue on a pop cycle is accepted (no drop).
- Queue storage: circular buffer; read/write pointers wrap modulo QDEPTH; no combinational path from btn to move_state.
- Reset mid-operation: pending entries are lost; move_state returns to INIT_DIR.
- Buttons held continuously generate exactly one press event.

Test Plan:
- Reset with INIT_DIR=3, then btn[0] pulsed for 40 cycles, tick at cycle 60 -> move_state=0, dir_changed pulses once, q_count back to 0.
- btn[2] glitch of DEB_CYCLES-2 cycles -> no press event; q_count stays 0 and move_state stays 3 across subsequent ticks.
- From RIGHT (3), press Up, then Left, before any tick:
  - -> q_count=2.
  - tick -> move_state=0.
  - tick -> move_state=2.
  - third tick -> no change, dir_changed=0.
- From RIGHT, press Left; then press Right when tail=3 -> both rejected, q_count=0, drop=0.
- QDEPTH=2: queue Up, then Left, then Down (valid vs tail 2) with no tick -> drop pulses once, q_count=2. Repeat the Down press on the cycle tick pops -> accepted, q_count stays 2, no drop.
- Assert rst_n=0 with q_count=2 mid-operation -> move_state=3, q_count=0 immediately, without waiting for a clk edge.
- btn[0] and btn[3] press simultaneously from LEFT -> Up queued, Right ignored, drop=0.
